// File: rtl/bp_be_multistream_prefetch_generator.sv
// Multi-stream stride prefetch generator.
// Each slot follows one striding load, walks its address forward one stride
// per cycle, and emits a prefetch.r dispatch packet whenever the walk enters
// a new cache block. Pending packets from all slots share one output port
// through a round-robin arbiter whose grant stays locked until consumed.

package bp_be_multistream_prefetch_generator_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef enum logic [5:0] {
    e_dcache_op_lb = 6'h00,
    e_dcache_op_lh = 6'h01,
    e_dcache_op_lw = 6'h02,
    e_dcache_op_ld = 6'h03
  } bp_be_dcache_fu_op_e;

  typedef enum logic [1:0] {
    e_int_byte  = 2'b00,
    e_int_hword = 2'b01,
    e_int_word  = 2'b10,
    e_int_dword = 2'b11
  } bp_be_int_tag_e;

  localparam logic [6:0] rv64_op_imm_opcode = 7'b0010011;

  // 7 single-bit flags + 6-bit fu_op + two 2-bit register tags
  localparam int bp_decode_width_gp = 17;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

  function automatic int bp_dpath_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 64;
      default:          return 64;
    endcase
  endfunction

  function automatic int bp_dcache_block_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 512;
      default:          return 512;
    endcase
  endfunction

  // v, nspec_v, pc, instr, rs1, rs2, imm, decode
  function automatic int bp_dispatch_pkt_width(bp_params_e cfg);
    return 2 + bp_vaddr_width(cfg) + 32 + 3 * bp_dpath_width(cfg) + bp_decode_width_gp;
  endfunction

endpackage

module bp_be_multistream_prefetch_generator
  import bp_be_multistream_prefetch_generator_pkg::*;
#(
  parameter bp_params_e bp_params_p    = e_bp_default_cfg,
  parameter int         streams_p      = 4,
  parameter int         loop_range_p   = 8,
  parameter int         stride_width_p = 12,
  localparam int vaddr_width_p         = bp_vaddr_width(bp_params_p),
  localparam int dpath_width_gp        = bp_dpath_width(bp_params_p),
  localparam int dcache_block_width_p  = bp_dcache_block_width(bp_params_p),
  localparam int dispatch_pkt_width_lp = bp_dispatch_pkt_width(bp_params_p),
  localparam int stream_id_width_lp    = (streams_p > 1) ? $clog2(streams_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             v_i,
  output logic                             ready_and_o,
  input  logic [vaddr_width_p-1:0]         pc_i,
  input  logic [vaddr_width_p-1:0]         eff_addr_i,
  input  logic [stride_width_p-1:0]        stride_i,
  input  logic [loop_range_p-1:0]          loop_counter_i,
  input  logic                             flush_i,
  output logic                             v_o,
  input  logic                             yumi_i,
  output logic [dispatch_pkt_width_lp-1:0] dispatch_pkt_o,
  output logic [stream_id_width_lp-1:0]    stream_id_o
);

  localparam int block_offset_lp = $clog2(dcache_block_width_p / 8);
  localparam int block_width_lp  = vaddr_width_p - block_offset_lp;
  localparam int id_w            = stream_id_width_lp;
  localparam logic [31:0] prefetch_r_instr_lp =
    {7'b0000000, 5'b00001, 5'b00000, 3'b110, 5'b00000, rv64_op_imm_opcode};

  typedef enum logic [1:0] {e_idle, e_step, e_send} slot_state_e;

  typedef struct packed {
    logic                pipe_mem_early_v;
    logic                spec_w_v;
    logic                score_v;
    logic                dcache_r_v;
    logic                mem_v;
    logic                prefetch;
    logic                irf_w_v;
    bp_be_dcache_fu_op_e fu_op;
    bp_be_int_tag_e      irs1_tag;
    bp_be_int_tag_e      ird_tag;
  } decode_s;

  typedef struct packed {
    logic                      v;
    logic                      nspec_v;
    logic [vaddr_width_p-1:0]  pc;
    logic [31:0]               instr;
    logic [dpath_width_gp-1:0] rs1;
    logic [dpath_width_gp-1:0] rs2;
    logic [dpath_width_gp-1:0] imm;
    decode_s                   decode;
  } dispatch_pkt_s;

  function automatic logic [vaddr_width_p-1:0] f_sext_stride(input logic signed [stride_width_p-1:0] s);
    logic signed [vaddr_width_p-1:0] ext;
    ext = vaddr_width_p'(s);
    return $unsigned(ext);
  endfunction

  function automatic logic [block_width_lp-1:0] f_block(input logic [vaddr_width_p-1:0] a);
    return a[vaddr_width_p-1:block_offset_lp];
  endfunction

  function automatic logic [vaddr_width_p-1:0] f_block_base(input logic [vaddr_width_p-1:0] a);
    return {a[vaddr_width_p-1:block_offset_lp], {block_offset_lp{1'b0}}};
  endfunction

  slot_state_e                      r_state  [streams_p];
  logic        [vaddr_width_p-1:0]  r_pc     [streams_p];
  logic        [vaddr_width_p-1:0]  r_addr   [streams_p];
  logic signed [stride_width_p-1:0] r_stride [streams_p];
  logic        [loop_range_p-1:0]   r_count  [streams_p];
  logic        [id_w-1:0]           r_rr_ptr;
  logic                             r_lock_v;
  logic        [id_w-1:0]           r_lock_id;

  logic [vaddr_width_p-1:0] w_next_addr  [streams_p];
  logic [loop_range_p-1:0]  w_next_count [streams_p];
  logic                     w_cross      [streams_p];
  logic                     w_idle_any, w_match, w_ready, w_load, w_v, w_rr_v, w_yumi, w_drop_grant;
  logic [id_w-1:0]          w_idle_id, w_match_id, w_load_id, w_rr_id, w_grant_id;
  dispatch_pkt_s            w_pkt;

  // Next walk position per slot and whether that step enters a new block
  always_comb begin
    for (int i = 0; i < streams_p; i++) begin
      w_next_addr[i]  = r_addr[i] + f_sext_stride(r_stride[i]);
      w_next_count[i] = r_count[i] - 1'b1;
      w_cross[i]      = f_block(w_next_addr[i]) != f_block(r_addr[i]);
    end
  end

  // Lowest-index free slot and lowest-index active slot tagged with pc_i
  always_comb begin
    w_idle_any = 1'b0;
    w_idle_id  = '0;
    w_match    = 1'b0;
    w_match_id = '0;
    for (int i = streams_p - 1; i >= 0; i--) begin
      if (r_state[i] == e_idle) begin
        w_idle_any = 1'b1;
        w_idle_id  = id_w'(i);
      end
      if ((r_state[i] != e_idle) && (r_pc[i] == pc_i)) begin
        w_match    = 1'b1;
        w_match_id = id_w'(i);
      end
    end
  end

  // Round-robin search over SEND slots starting at the pointer
  always_comb begin
    w_rr_v  = 1'b0;
    w_rr_id = '0;
    for (int k = streams_p - 1; k >= 0; k--) begin
      if (r_state[(int'(r_rr_ptr) + k) % streams_p] == e_send) begin
        w_rr_v  = 1'b1;
        w_rr_id = id_w'((int'(r_rr_ptr) + k) % streams_p);
      end
    end
  end

  assign w_ready      = (w_idle_any | w_match) & ~flush_i;
  assign w_load       = v_i & w_ready & (loop_counter_i != '0);
  assign w_load_id    = w_match ? w_match_id : w_idle_id;
  assign w_v          = w_rr_v;
  assign w_grant_id   = r_lock_v ? r_lock_id : w_rr_id;
  assign w_yumi       = yumi_i & w_v;
  // Re-arming the slot currently on the output discards its packet
  assign w_drop_grant = w_load & w_match & (w_match_id == w_grant_id);

  // Slot FSMs, round-robin pointer and output lock
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < streams_p; i++) r_state[i] <= e_idle;
      r_rr_ptr  <= '0;
      r_lock_v  <= 1'b0;
      r_lock_id <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < streams_p; i++) r_state[i] <= e_idle;
      r_lock_v <= 1'b0;
    end else begin
      for (int i = 0; i < streams_p; i++) begin
        unique case (r_state[i])
          e_step: begin
            if (w_cross[i])                  r_state[i] <= e_send;
            else if (w_next_count[i] == '0) r_state[i] <= e_idle;
          end
          e_send: begin
            if (w_yumi && (w_grant_id == id_w'(i)))
              r_state[i] <= (r_count[i] == '0) ? e_idle : e_step;
          end
          default: ;
        endcase
      end
      if (w_load) r_state[w_load_id] <= e_step;
      if (w_yumi) r_rr_ptr <= (int'(w_grant_id) == streams_p - 1) ? '0 : w_grant_id + 1'b1;
      if (w_yumi || w_drop_grant) begin
        r_lock_v <= 1'b0;
      end else if (w_v) begin
        r_lock_v  <= 1'b1;
        r_lock_id <= w_grant_id;
      end
    end
  end

  // Slot payload: loaded on acceptance, advanced while walking
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < streams_p; i++) begin
      if (w_load && (w_load_id == id_w'(i))) begin
        r_pc[i]     <= pc_i;
        r_addr[i]   <= eff_addr_i;
        r_stride[i] <= $signed(stride_i);
        r_count[i]  <= loop_counter_i;
      end else if (r_state[i] == e_step) begin
        r_addr[i]  <= w_next_addr[i];
        r_count[i] <= w_next_count[i];
      end
    end
  end

  // prefetch.r packet for the granted slot; all-zero when idle
  always_comb begin
    w_pkt = '0;
    if (w_v) begin
      w_pkt.v                       = 1'b1;
      w_pkt.nspec_v                 = 1'b1;
      w_pkt.pc                      = r_pc[w_grant_id];
      w_pkt.instr                   = prefetch_r_instr_lp;
      w_pkt.rs1                     = dpath_width_gp'(f_block_base(r_addr[w_grant_id]));
      w_pkt.decode.pipe_mem_early_v = 1'b1;
      w_pkt.decode.spec_w_v         = 1'b1;
      w_pkt.decode.score_v          = 1'b1;
      w_pkt.decode.dcache_r_v       = 1'b1;
      w_pkt.decode.mem_v            = 1'b1;
      w_pkt.decode.prefetch         = 1'b1;
      w_pkt.decode.irf_w_v          = 1'b0;
      w_pkt.decode.fu_op            = e_dcache_op_lb;
      w_pkt.decode.irs1_tag         = e_int_word;
      w_pkt.decode.ird_tag          = e_int_word;
    end
  end

  assign ready_and_o    = w_ready;
  assign v_o            = w_v;
  assign stream_id_o    = w_v ? w_grant_id : '0;
  assign dispatch_pkt_o = w_pkt;

endmodule

// File: tb/tb_bp_be_multistream_prefetch_generator.sv
// Scoreboard bench for the multi-stream prefetch generator (default config:
// 39-bit vaddr, 64-bit datapath, 64-byte blocks, 4 slots).
module tb_bp_be_multistream_prefetch_generator;

  localparam int VW = 39;
  localparam int PW = 282;

  logic          clk;
  logic          reset_i, v_i, flush_i, yumi_i;
  logic          ready_and_o, v_o;
  logic [VW-1:0] pc_i, eff_addr_i;
  logic [11:0]   stride_i;
  logic [7:0]    loop_counter_i;
  logic [PW-1:0] dispatch_pkt_o;
  logic [1:0]    stream_id_o;

  bp_be_multistream_prefetch_generator dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_and_o(ready_and_o),
    .pc_i(pc_i), .eff_addr_i(eff_addr_i), .stride_i(stride_i),
    .loop_counter_i(loop_counter_i), .flush_i(flush_i), .v_o(v_o),
    .yumi_i(yumi_i), .dispatch_pkt_o(dispatch_pkt_o), .stream_id_o(stream_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [VW-1:0] pc;
    logic [VW-1:0] rs1;
    logic [1:0]    id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   yumi_en = 1'b0;

  function automatic logic [PW-1:0] exp_pkt(input logic [VW-1:0] pc, input logic [VW-1:0] rs1);
    return {1'b1, 1'b1, pc, 32'h0010_6013, {25'b0, rs1}, 64'b0, 64'b0,
            7'b111_1110, 6'b000000, 2'b10, 2'b10};
  endfunction

  function automatic void push_exp(input logic [VW-1:0] pc, input logic [VW-1:0] rs1, input logic [1:0] id);
    exp_t e;
    e.pc = pc; e.rs1 = rs1; e.id = id;
    q.push_back(e);
  endfunction

  // Reference walk of one stream: a packet whenever the address enters a new 64-byte block
  function automatic void push_stream(input logic [VW-1:0] pc, input logic [VW-1:0] eff,
                                      input int stride, input int cnt, input logic [1:0] id);
    logic [VW-1:0] a, n;
    a = eff;
    for (int k = 0; k < cnt; k++) begin
      n = a + VW'(stride);
      if (n[VW-1:6] != a[VW-1:6]) push_exp(pc, {n[VW-1:6], 6'b0}, id);
      a = n;
    end
  endfunction

  // Scoreboard: every consumed packet is compared with the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset_i && !flush_i && v_o && yumi_i) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pkt id=%0d pkt=%h", stream_id_o, dispatch_pkt_o);
      end else begin
        e = q.pop_front();
        checks++;
        if (dispatch_pkt_o !== exp_pkt(e.pc, e.rs1)) begin
          errors++;
          $display("FAIL pkt got=%h exp=%h", dispatch_pkt_o, exp_pkt(e.pc, e.rs1));
        end
        checks++;
        if (stream_id_o !== e.id) begin
          errors++;
          $display("FAIL stream_id got=%0d exp=%0d", stream_id_o, e.id);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    yumi_i = yumi_en && v_o;
  endtask

  task automatic send_desc(input logic [VW-1:0] pc, input logic [VW-1:0] eff, input int stride, input int cnt);
    cyc();
    v_i = 1'b1; pc_i = pc; eff_addr_i = eff; stride_i = 12'(stride); loop_counter_i = 8'(cnt);
    cyc();
    v_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && q.size() != 0; k++) cyc();
  endtask

  task automatic wait_vo(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (v_o) begin seen = 1'b1; break; end
      cyc();
    end
  endtask

  task automatic apply_reset();
    cyc(); reset_i = 1'b1;
    cyc(); cyc();
    reset_i = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) cyc();
    reset_i = 1'b0;
    cyc(); #1;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got=%b exp=0", v_o); end
    checks++; if (ready_and_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_and_o); end
    checks++; if (stream_id_o !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", stream_id_o); end
  endtask

  task automatic test_single_stream();
    int nv = 0;
    yumi_en = 1'b1;
    push_exp(39'h100, 39'h1040, 2'd0);
    push_exp(39'h100, 39'h1080, 2'd0);
    send_desc(39'h100, 39'h1000, 16, 8);
    wait_drain(60);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL single_drain left=%0d exp=0", q.size()); q.delete(); end
    repeat (10) begin cyc(); if (v_o) nv++; end
    checks++; if (nv != 0) begin errors++; $display("FAIL single_extra got=%0d exp=0", nv); end
  endtask

  task automatic test_negative_stride();
    yumi_en = 1'b1;
    push_exp(39'h200, 39'h1FC0, 2'd0);
    push_exp(39'h200, 39'h1F80, 2'd0);
    push_exp(39'h200, 39'h1F40, 2'd0);
    send_desc(39'h200, 39'h2000, -64, 3);
    wait_drain(60);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL neg_drain left=%0d exp=0", q.size()); q.delete(); end
  endtask

  task automatic test_zero_stride();
    int nv = 0;
    yumi_en = 1'b1;
    send_desc(39'h300, 39'h3000, 0, 5);
    repeat (12) begin cyc(); if (v_o) nv++; end
    checks++; if (nv != 0) begin errors++; $display("FAIL zero_stride_pkts got=%0d exp=0", nv); end
    #1;
    checks++; if (ready_and_o !== 1'b1) begin errors++; $display("FAIL zero_stride_ready got=%b exp=1", ready_and_o); end
  endtask

  task automatic test_large_stride();
    yumi_en = 1'b1;
    for (int k = 1; k <= 4; k++) push_exp(39'h400, 39'h3000 + VW'(128 * k), 2'd0);
    send_desc(39'h400, 39'h3000, 128, 4);
    wait_drain(60);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL large_drain left=%0d exp=0", q.size()); q.delete(); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    yumi_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push_exp(39'hA0, 39'h4000 + VW'(64 * k), 2'd0);
      push_exp(39'hA1, 39'h8000 + VW'(64 * k), 2'd1);
    end
    send_desc(39'hA0, 39'h4000, 64, 4);
    send_desc(39'hA1, 39'h8000, 64, 4);
    wait_drain(80);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rr_drain left=%0d exp=0", q.size()); q.delete(); end
  endtask

  task automatic test_hold();
    bit seen;
    apply_reset();
    yumi_en = 1'b0;
    send_desc(39'h55, 39'h5000, 64, 2);
    wait_vo(20, seen);
    checks++; if (!seen) begin errors++; $display("FAIL hold_vo got=0 exp=1"); end
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      checks++;
      if (dispatch_pkt_o !== exp_pkt(39'h55, 39'h5040) || stream_id_o !== 2'd0 || v_o !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d got=%h/%0d exp=%h/0", k, dispatch_pkt_o, stream_id_o, exp_pkt(39'h55, 39'h5040));
      end
    end
    push_exp(39'h55, 39'h5040, 2'd0);
    push_exp(39'h55, 39'h5080, 2'd0);
    yumi_en = 1'b1;
    wait_drain(40);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL hold_drain left=%0d exp=0", q.size()); q.delete(); end
  endtask

  task automatic test_all_busy();
    apply_reset();
    yumi_en = 1'b0;
    for (int s = 0; s < 4; s++) send_desc(39'h10 + VW'(s), 39'h0, 0, 200);
    cyc();
    v_i = 1'b1; pc_i = 39'h99; eff_addr_i = 39'h6000; stride_i = 12'd64; loop_counter_i = 8'd1;
    #1;
    checks++; if (ready_and_o !== 1'b0) begin errors++; $display("FAIL busy_nomatch_ready got=%b exp=0", ready_and_o); end
    pc_i = 39'h12;
    #1;
    checks++; if (ready_and_o !== 1'b1) begin errors++; $display("FAIL busy_match_ready got=%b exp=1", ready_and_o); end
    push_exp(39'h12, 39'h6040, 2'd2);
    cyc();
    v_i = 1'b0;
    yumi_en = 1'b1;
    wait_drain(40);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL busy_rearm left=%0d exp=0", q.size()); q.delete(); end
    cyc(); flush_i = 1'b1; #1;
    checks++; if (ready_and_o !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", ready_and_o); end
    cyc(); flush_i = 1'b0;
  endtask

  task automatic test_same_slot_rearm();
    bit seen;
    int nv = 0;
    apply_reset();
    yumi_en = 1'b0;
    send_desc(39'h77, 39'h9000, 64, 3);
    wait_vo(20, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rearm_vo got=0 exp=1"); end
    cyc();
    push_exp(39'h77, 39'h9040, 2'd0);
    push_exp(39'h77, 39'hA040, 2'd0);
    yumi_i = 1'b1;
    v_i = 1'b1; pc_i = 39'h77; eff_addr_i = 39'hA000; stride_i = 12'd64; loop_counter_i = 8'd1;
    cyc();
    v_i = 1'b0;
    yumi_en = 1'b1;
    wait_drain(40);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rearm_drain left=%0d exp=0", q.size()); q.delete(); end
    repeat (10) begin cyc(); if (v_o) nv++; end
    checks++; if (nv != 0) begin errors++; $display("FAIL rearm_old_stream got=%0d exp=0", nv); end
  endtask

  task automatic test_flush();
    bit seen;
    int nv = 0;
    yumi_en = 1'b0;
    send_desc(39'h88, 39'hB000, 64, 4);
    wait_vo(20, seen);
    checks++; if (!seen) begin errors++; $display("FAIL flush_pre_vo got=0 exp=1"); end
    cyc();
    flush_i = 1'b1; yumi_i = 1'b1;
    cyc();
    flush_i = 1'b0; #1;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL flush_v_o got=%b exp=0", v_o); end
    checks++; if (ready_and_o !== 1'b1) begin errors++; $display("FAIL flush_idle_ready got=%b exp=1", ready_and_o); end
    repeat (10) begin cyc(); if (v_o) nv++; end
    checks++; if (nv != 0) begin errors++; $display("FAIL flush_after got=%0d exp=0", nv); end
  endtask

  task automatic test_reset_midstream();
    bit seen;
    int nv = 0;
    yumi_en = 1'b0;
    send_desc(39'h66, 39'hC000, 64, 4);
    send_desc(39'h67, 39'hD000, 64, 4);
    wait_vo(20, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rst_pre_vo got=0 exp=1"); end
    cyc();
    reset_i = 1'b1; yumi_i = 1'b1;
    cyc();
    reset_i = 1'b0; #1;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL rst_mid_v_o got=%b exp=0", v_o); end
    checks++; if (stream_id_o !== 2'd0) begin errors++; $display("FAIL rst_mid_id got=%0d exp=0", stream_id_o); end
    checks++; if (ready_and_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", ready_and_o); end
    repeat (10) begin cyc(); if (v_o) nv++; end
    checks++; if (nv != 0) begin errors++; $display("FAIL rst_mid_after got=%0d exp=0", nv); end
  endtask

  task automatic test_random_streams();
    logic [VW-1:0] pc, eff;
    int stride, cnt;
    yumi_en = 1'b1;
    for (int n = 0; n < 10; n++) begin
      pc     = {7'b0, $urandom};
      eff    = {7'b0, $urandom};
      stride = int'($urandom_range(0, 400)) - 200;
      cnt    = int'($urandom_range(1, 20));
      push_stream(pc, eff, stride, cnt, 2'd0);
      send_desc(pc, eff, stride, cnt);
      wait_drain(200);
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL random_drain n=%0d left=%0d exp=0", n, q.size());
        q.delete();
      end
      repeat (25) cyc();
    end
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; flush_i = 1'b0; yumi_i = 1'b0;
    pc_i = '0; eff_addr_i = '0; stride_i = '0; loop_counter_i = '0;
    test_reset();
    test_single_stream();
    test_negative_stride();
    test_zero_stride();
    test_large_stride();
    test_round_robin();
    test_hold();
    test_all_busy();
    test_same_slot_rearm();
    test_flush();
    test_reset_midstream();
    test_random_streams();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_be_multistream_prefetch_generator.md
BP_BE_MULTISTREAM_PREFETCH_GENERATOR -- requirements
Module: bp_be_multistream_prefetch_generator

Interface
REQ-001 The block SHALL have parameter bp_params_p, default e_bp_default_cfg, meaning the processor configuration supplying vaddr_width_p, dpath_width_gp and dcache_block_width_p.
REQ-002 The block SHALL have parameter streams_p, default 4, meaning the number of independent prefetch stream slots (1..16).
REQ-003 The block SHALL have parameter loop_range_p, default 8, meaning the width of the loop-count input.
REQ-004 The block SHALL have parameter stride_width_p, default 12, meaning the width of the signed stride input.
REQ-005 The block SHALL have a port clk_i, input, 1 bit: the clock; the block SHALL use this single clock.
REQ-006 The block SHALL have a port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have a port v_i, input, 1 bit: a striding-load descriptor is valid.
REQ-008 The block SHALL have a port ready_and_o, output, 1 bit: the block can accept a descriptor.
REQ-009 The block SHALL have a port pc_i, input, vaddr_width_p bits: the PC of the striding load (the stream tag).
REQ-010 The block SHALL have a port eff_addr_i, input, vaddr_width_p bits: the demand effective address.
REQ-011 The block SHALL have a port stride_i, input, stride_width_p bits: the two's-complement byte stride.
REQ-012 The block SHALL have a port loop_counter_i, input, loop_range_p bits: the remaining iterations.
REQ-013 The block SHALL have a port flush_i, input, 1 bit: kill all streams.
REQ-014 The block SHALL have a port v_o, output, 1 bit: a prefetch dispatch packet is valid.
REQ-015 The block SHALL have a port yumi_i, input, 1 bit: the consumer takes the packet this cycle; yumi_i is legal only when v_o is high.
REQ-016 The block SHALL have a port dispatch_pkt_o, output, bp_be_dispatch_pkt width: the prefetch packet.
REQ-017 The block SHALL have a port stream_id_o, output, clog2(streams_p) bits: the slot owning the current packet.

Function
REQ-018 The block SHALL give each slot the fields state {IDLE, STEP, SEND}, pc, addr, stride, count and block, where block = addr[vaddr_width_p-1:log2(dcache_block_width_p/8)].
REQ-019 ready_and_o SHALL equal (some slot is IDLE, or pc_i matches an active slot's pc) AND NOT flush_i.
REQ-020 On acceptance (v_i & ready_and_o) with loop_counter_i != 0, a matching active slot SHALL be re-armed; otherwise the lowest-index IDLE slot SHALL be loaded with addr = eff_addr_i, count = loop_counter_i and state STEP.
REQ-021 On acceptance with loop_counter_i == 0, the descriptor SHALL be consumed with no slot change.
REQ-022 The block SHALL NOT prefetch the block containing eff_addr_i, because the demand load fetches it.
REQ-023 In STEP, each cycle the slot SHALL set addr to addr + sign-extended stride (mod 2^vaddr_width_p) and count to count - 1.
REQ-024 In STEP, if the new block differs from the old block, the slot SHALL go to SEND; else if the new count is 0 it SHALL go to IDLE; else it SHALL stay in STEP.
REQ-025 In SEND, the slot SHALL hold until granted and yumi_i, then go to IDLE if count == 0, else to STEP.
REQ-026 v_o SHALL be the OR of all slots in SEND.
REQ-027 Among SEND slots, the grant SHALL be round-robin starting from the slot after the last yumi'd slot.
REQ-028 The grant SHALL be locked while v_o & ~yumi_i, so that dispatch_pkt_o and stream_id_o stay stable until yumi_i.
REQ-029 A slot in SEND that is being re-armed SHALL drop its pending packet; if it is the locked grant, the lock SHALL release.
REQ-030 dispatch_pkt_o SHALL be all-zero except for the fields listed in REQ-031 through REQ-034.
REQ-031 The packet SHALL set v = 1, nspec_v = 1 and pc = slot pc.
REQ-032 The packet SHALL set rs1 = slot addr with the low log2(dcache_block_width_p/8) bits cleared, zero-extended to dpath_width_gp.
REQ-033 The packet SHALL set instr = prefetch.r, encoded as opcode OP_IMM, funct3 3'b110, rs2 5'b00001, with rs1 and all immediates 0.
REQ-034 The packet SHALL set decode with pipe_mem_early_v, spec_w_v, score_v, dcache_r_v, mem_v and prefetch set to 1; irf_w_v = 0; fu_op = e_dcache_op_lb; and irs1_tag = ird_tag = e_int_word.
REQ-035 If flush_i is high, all slots SHALL be IDLE in the next cycle and any yumi_i in that cycle SHALL be ignored.
REQ-036 A stride of 0 SHALL drain count in STEP and emit no packet.
REQ-037 A stride of at least the block size SHALL produce one packet per iteration.
REQ-038 Acceptance and yumi_i SHALL be able to occur in the same cycle, on different or on the same slot; the same-slot case is resolved by REQ-029.

Reset
REQ-039 While reset_i is high (synchronous), all slots SHALL go to IDLE, the round-robin pointer SHALL be set to 0 and the lock SHALL be cleared.
REQ-040 From the cycle after reset, v_o SHALL be 0, ready_and_o SHALL be 1 (when flush_i is 0), and stream_id_o SHALL be 0.
REQ-041 Reset asserted mid-stream SHALL abandon all pending packets with no further v_o.

Verification
REQ-042 A single stream with 64-byte blocks, eff_addr 0x1000, stride 16 and count 8 SHALL produce packets with rs1 0x1040, then 0x1080, then no more.
REQ-043 A negative stride of -64 with eff_addr 0x2000 and count 3 SHALL produce packets with rs1 0x1FC0, 0x1F80 and 0x1F40.
REQ-044 Streams loaded into slots 0 and 1 with stride 64 and count 4, with yumi_i held high, SHALL produce stream_id_o alternating 0,1,0,1,...
REQ-045 When v_o is held with yumi_i low for 5 cycles, dispatch_pkt_o and stream_id_o SHALL stay unchanged.
REQ-046 With all slots busy and a new, non-matching pc, ready_and_o SHALL be 0; a matching pc SHALL be accepted and SHALL re-arm that slot.
REQ-047 flush_i asserted, or reset_i asserted, during an active SEND SHALL produce v_o = 0 in the next cycle and all slots IDLE.
